// File: rtl/cache_tag_nway.sv
// N-way set-associative tag store with tree pseudo-LRU replacement and
// a miss FSM that sequences write-back, refill and invalidate sweeps.
module cache_tag_nway #(
   parameter int WAYS        = 2,
   parameter int SET_BITS    = 6,
   parameter int OFFSET_BITS = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            cached,
   input  logic            sram_en,
   input  logic            sram_we,
   input  logic [31:0]     sram_addr,
   input  logic            inv_all,
   output logic            stallreq,
   output logic [WAYS-1:0] hit,
   output logic [WAYS-1:0] victim,
   output logic            wb_req,
   output logic [31:0]     wb_addr,
   input  logic            wb_done,
   output logic            rd_req,
   output logic [31:0]     rd_addr,
   input  logic            rd_done,
   output logic            inv_busy
);

   localparam int TAG_BITS = 32 - SET_BITS - OFFSET_BITS;
   localparam int SETS     = 1 << SET_BITS;
   localparam int PB       = WAYS - 1;
   localparam int IW       = (WAYS > 2) ? 2 : 1;

   typedef enum logic [1:0] {IDLE, WB, REFILL, INV} state_t;

   state_t state, state_n;

   logic [WAYS-1:0]     valid_q [SETS];
   logic [WAYS-1:0]     dirty_q [SETS];
   logic [PB-1:0]       plru_q  [SETS];
   logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];

   logic [SET_BITS-1:0] cnt;
   logic [SET_BITS-1:0] lat_idx;
   logic [TAG_BITS-1:0] lat_tag;
   logic [IW-1:0]       lat_vic;
   logic [31:0]         wb_addr_q;
   logic [31:0]         rd_addr_q;

   logic [SET_BITS-1:0] idx;
   logic [TAG_BITS-1:0] tag;
   logic                lookup;
   logic                miss;
   logic [WAYS-1:0]     hit_c;
   logic [IW-1:0]       hit_idx;
   logic [IW-1:0]       vic_idx;
   logic [2:0]          p3;
   logic [1:0]          v2;
   logic                unused_ok;

   assign idx       = sram_addr[OFFSET_BITS +: SET_BITS];
   assign tag       = sram_addr[31 -: TAG_BITS];
   assign lookup    = cached & sram_en & ~flush;
   assign unused_ok = ^sram_addr[OFFSET_BITS-1:0];

   // tree bits point at the victim; touching a way points them away from it
   function automatic logic [2:0] plru_touch(input logic [2:0] p,
                                             input logic [1:0] w);
      logic [2:0] r;
      r = p;
      if (WAYS == 2) begin
         r[0] = ~w[0];
      end else if (!w[1]) begin
         r[0] = 1'b1;
         r[1] = ~w[0];
      end else begin
         r[0] = 1'b0;
         r[2] = ~w[0];
      end
      return r;
   endfunction

   always_comb begin
      hit_c   = '0;
      hit_idx = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (lookup && state == IDLE && valid_q[idx][w] &&
             tag_q[idx][w] == tag) begin
            hit_c[w] = 1'b1;
            hit_idx  = IW'(w);
         end
      end
   end

   always_comb begin
      p3 = 3'(plru_q[idx]);
      v2 = '0;
      if (WAYS == 4)
         v2 = p3[0] ? (p3[2] ? 2'd3 : 2'd2) : (p3[1] ? 2'd1 : 2'd0);
      else
         v2 = {1'b0, p3[0]};
      vic_idx = IW'(v2);
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid_q[idx][w]) vic_idx = IW'(w);
   end

   assign miss     = lookup && state == IDLE && !(|hit_c);
   assign stallreq = miss || state != IDLE;
   assign hit      = hit_c;
   assign wb_req   = state == WB;
   assign rd_req   = state == REFILL;
   assign inv_busy = state == INV;
   assign wb_addr  = wb_addr_q;
   assign rd_addr  = rd_addr_q;

   always_comb begin
      victim  = '0;
      state_n = state;
      unique case (state)
         IDLE: begin
            if (miss) victim = WAYS'(1) << vic_idx;
            if (inv_all)
               state_n = INV;
            else if (miss)
               state_n = (valid_q[idx][vic_idx] && dirty_q[idx][vic_idx])
                         ? WB : REFILL;
         end
         WB: begin
            victim = WAYS'(1) << lat_vic;
            if (wb_done) state_n = REFILL;
         end
         REFILL: begin
            victim = WAYS'(1) << lat_vic;
            if (rd_done) state_n = IDLE;
         end
         INV: begin
            if (cnt == '1) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_idx   <= '0;
         lat_tag   <= '0;
         lat_vic   <= '0;
         wb_addr_q <= '0;
         rd_addr_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state <= state_n;
         unique case (state)
            IDLE: begin
               if (inv_all) begin
                  cnt <= '0;
               end else if (miss) begin
                  lat_idx   <= idx;
                  lat_tag   <= tag;
                  lat_vic   <= vic_idx;
                  rd_addr_q <= {tag, idx, {OFFSET_BITS{1'b0}}};
                  wb_addr_q <= {tag_q[idx][vic_idx], idx,
                                {OFFSET_BITS{1'b0}}};
               end
               if (|hit_c) begin
                  plru_q[idx] <= PB'(plru_touch(3'(plru_q[idx]),
                                                2'(hit_idx)));
                  if (sram_we) dirty_q[idx][hit_idx] <= 1'b1;
               end
            end
            REFILL: begin
               if (rd_done) begin
                  valid_q[lat_idx][lat_vic] <= 1'b1;
                  dirty_q[lat_idx][lat_vic] <= 1'b0;
                  tag_q[lat_idx][lat_vic]   <= lat_tag;
                  plru_q[lat_idx] <= PB'(plru_touch(3'(plru_q[lat_idx]),
                                                    2'(lat_vic)));
               end
            end
            INV: begin
               // dirty lines are dropped on purpose: no write-back
               valid_q[cnt] <= '0;
               dirty_q[cnt] <= '0;
               plru_q[cnt]  <= '0;
               cnt          <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_tag_nway.sv
// Directed bench for cache_tag_nway (4 ways, 64 sets, 64-byte lines).
// Expected values are hand-derived from the PLRU tree and FSM timing.
module tb_cache_tag_nway;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        cached;
   logic        sram_en;
   logic        sram_we;
   logic [31:0] sram_addr;
   logic        inv_all;
   logic        stallreq;
   logic [3:0]  hit;
   logic [3:0]  victim;
   logic        wb_req;
   logic [31:0] wb_addr;
   logic        wb_done;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        rd_done;
   logic        inv_busy;

   int checks = 0;
   int errors = 0;
   int n;

   cache_tag_nway #(.WAYS(4), .SET_BITS(6), .OFFSET_BITS(6)) dut (
      .clk(clk), .rst(rst), .flush(flush), .cached(cached),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .inv_all(inv_all), .stallreq(stallreq), .hit(hit),
      .victim(victim), .wb_req(wb_req), .wb_addr(wb_addr),
      .wb_done(wb_done), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_done(rd_done), .inv_busy(inv_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic look(input logic [31:0] a, input logic we);
      sram_en   = 1'b1;
      cached    = 1'b1;
      flush     = 1'b0;
      sram_addr = a;
      sram_we   = we;
   endtask

   task automatic chk(input string t, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", t, obs, exp);
      end
   endtask

   // miss to a clean/invalid victim, answered with an immediate rd_done
   task automatic fill(input logic [31:0] a);
      cyc(); look(a, 1'b0);
      cyc(); rd_done = 1'b1;
      cyc(); rd_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; cached = 1'b0; sram_en = 1'b0;
      sram_we = 1'b0; sram_addr = '0; inv_all = 1'b0;
      wb_done = 1'b0; rd_done = 1'b0;
      repeat (2) cyc();
      rst = 1'b0;
      cyc(); #1;
      chk("rst_hit", 32'(hit), 0);
      chk("rst_victim", 32'(victim), 0);
      chk("rst_wb_req", 32'(wb_req), 0);
      chk("rst_rd_req", 32'(rd_req), 0);
      chk("rst_inv_busy", 32'(inv_busy), 0);
      chk("rst_stall", 32'(stallreq), 0);
      chk("rst_wb_addr", wb_addr, 0);
      chk("rst_rd_addr", rd_addr, 0);

      cyc(); look(32'h0000_1040, 1'b0); #1;
      chk("t1_stall", 32'(stallreq), 1);
      chk("t1_hit", 32'(hit), 0);
      cyc(); #1;
      chk("t1_rd_req", 32'(rd_req), 1);
      chk("t1_rd_addr", rd_addr, 32'h0000_1040);
      chk("t1_wb_req", 32'(wb_req), 0);
      rd_done = 1'b1;
      cyc(); rd_done = 1'b0; #1;
      chk("t1_hit_after", 32'(hit), 4'b0001);
      chk("t1_stall_after", 32'(stallreq), 0);
      chk("t1_rd_req_low", 32'(rd_req), 0);

      fill(32'h0000_2040);
      fill(32'h0000_3040);
      fill(32'h0000_4040); #1;
      chk("t4_hit", 32'(hit), 4'b1000);
      cyc(); look(32'h0000_1040, 1'b0); #1;
      chk("t1_rehit", 32'(hit), 4'b0001);
      cyc(); look(32'h0000_5040, 1'b0); #1;
      chk("t5_hit", 32'(hit), 0);
      chk("t5_victim", 32'(victim), 4'b0100);
      chk("t5_stall", 32'(stallreq), 1);
      cyc(); #1;
      chk("t5_rd_addr", rd_addr, 32'h0000_5040);
      rd_done = 1'b1;
      cyc(); rd_done = 1'b0; #1;
      chk("t5_hit_after", 32'(hit), 4'b0100);

      cyc(); look(32'h0000_2040, 1'b1); #1;
      chk("t2_store_hit", 32'(hit), 4'b0010);
      cyc(); look(32'h0000_1040, 1'b0);
      cyc(); look(32'h0000_4040, 1'b0); #1;
      chk("t4_hit2", 32'(hit), 4'b1000);
      cyc(); look(32'h0000_7040, 1'b0); #1;
      chk("t7_victim", 32'(victim), 4'b0010);
      chk("t7_stall", 32'(stallreq), 1);
      cyc(); #1;
      chk("wb_req_on", 32'(wb_req), 1);
      chk("wb_addr", wb_addr, 32'h0000_2040);
      chk("wb_rd_req_off", 32'(rd_req), 0);
      cyc(); #1;
      chk("wb_req_held", 32'(wb_req), 1);
      wb_done = 1'b1;
      cyc(); wb_done = 1'b0; #1;
      chk("wb_req_off", 32'(wb_req), 0);
      chk("wb_then_rd", 32'(rd_req), 1);
      chk("t7_rd_addr", rd_addr, 32'h0000_7040);
      rd_done = 1'b1;
      cyc(); rd_done = 1'b0; #1;
      chk("t7_hit", 32'(hit), 4'b0010);

      cyc(); look(32'h0000_3040, 1'b0); #1;
      chk("t3_miss_hit", 32'(hit), 0);
      chk("t3_miss_stall", 32'(stallreq), 1);
      chk("t3_victim", 32'(victim), 4'b0100);
      cyc(); rd_done = 1'b1;
      cyc(); rd_done = 1'b0;

      cyc(); look(32'h0000_9040, 1'b0); flush = 1'b1; #1;
      chk("flush_stall", 32'(stallreq), 0);
      chk("flush_hit", 32'(hit), 0);
      cyc(); #1;
      chk("flush_no_rd", 32'(rd_req), 0);
      chk("flush_no_stall", 32'(stallreq), 0);
      cyc(); look(32'h0000_1040, 1'b0); cached = 1'b0; #1;
      chk("uncached_hit", 32'(hit), 0);
      chk("uncached_stall", 32'(stallreq), 0);
      cyc(); look(32'h0000_1040, 1'b1); #1;
      chk("dirty_store_hit", 32'(hit), 4'b0001);

      cyc(); sram_en = 1'b0; inv_all = 1'b1; #1;
      chk("inv_start_stall", 32'(stallreq), 0);
      cyc(); inv_all = 1'b0; #1;
      chk("inv_stall", 32'(stallreq), 1);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         if (!inv_busy) break;
         n++;
         cyc();
      end
      chk("inv_cycles", 32'(n), 64);
      look(32'h0000_1040, 1'b0); #1;
      chk("post_inv_hit", 32'(hit), 0);
      chk("post_inv_stall", 32'(stallreq), 1);
      chk("post_inv_victim", 32'(victim), 4'b0001);
      cyc(); #1;
      chk("post_inv_no_wb", 32'(wb_req), 0);
      chk("post_inv_rd", 32'(rd_req), 1);
      rd_done = 1'b1;
      cyc(); rd_done = 1'b0; #1;
      chk("post_inv_fill", 32'(hit), 4'b0001);

      cyc(); look(32'h0000_1040, 1'b1); #1;
      chk("rw_store_hit", 32'(hit), 4'b0001);
      fill(32'h0000_2040);
      fill(32'h0000_3040);
      fill(32'h0000_4040);
      cyc(); look(32'h0000_8040, 1'b0); #1;
      chk("rw_victim", 32'(victim), 4'b0001);
      cyc(); #1;
      chk("rw_wb_req", 32'(wb_req), 1);
      chk("rw_wb_addr", wb_addr, 32'h0000_1040);
      rst = 1'b1;
      cyc(); rst = 1'b0; sram_en = 1'b0; #1;
      chk("rst_mid_wb_req", 32'(wb_req), 0);
      chk("rst_mid_rd_req", 32'(rd_req), 0);
      chk("rst_mid_stall", 32'(stallreq), 0);
      cyc(); look(32'h0000_1040, 1'b0); #1;
      chk("rst_mid_miss_hit", 32'(hit), 0);
      chk("rst_mid_miss_stall", 32'(stallreq), 1);
      cyc(); #1;
      chk("rst_mid_refill", 32'(rd_req), 1);
      chk("rst_mid_no_wb", 32'(wb_req), 0);
      rd_done = 1'b1;
      cyc(); rd_done = 1'b0; sram_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
